// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg : menu indices, cursor state and joystick direction encodings
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pong_pkg;

  localparam logic [1:0] MENU_CONTINUE = 2'd0;
  localparam logic [1:0] MENU_RESTART  = 2'd1;
  localparam logic [1:0] MENU_EXIT     = 2'd2;

  typedef enum logic [1:0] {
    CUR_LOCKED = 2'd0,
    CUR_IDLE   = 2'd1,
    CUR_DELAY  = 2'd2,
    CUR_REPEAT = 2'd3
  } cursor_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  // Both or neither pressed is treated as no direction.
  function automatic dir_e decode_dir(input logic up, input logic down);
    if (up && !down)      return DIR_UP;
    else if (down && !up) return DIR_DN;
    else                  return DIR_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/menu_cursor_if.sv
// ---------------------------------------------------------------------------
// menu_cursor_if : joystick/enable inputs and cursor outputs of menu_cursor
// Rev 1.0        : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface menu_cursor_if;
  logic       enable;
  logic       up;
  logic       down;
  logic [1:0] value;
  logic       moved;

  modport master (output enable, output up, output down, input value, input moved);
  modport slave  (input enable, input up, input down, output value, output moved);
endinterface

`default_nettype wire

// File: rtl/hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer : reloadable hold counter with delay/rate limit select
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hold_timer #(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic load_i,
  input  logic run_i,
  input  logic limit_sel_i,
  output logic expire_o
);

  localparam int MAX_LIMIT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW        = $clog2(MAX_LIMIT + 1);
  localparam logic [CW-1:0] DELAY_LIM = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_LIM  = CW'(REPEAT_RATE);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] limit;

  // Load writes 1 because the loading edge already counts as the first held cycle.
  always_comb begin
    limit    = limit_sel_i ? RATE_LIM : DELAY_LIM;
    expire_o = run_i && (count_q == limit);
    count_d  = count_q;
    if (clear_i)
      count_d = '0;
    else if (load_i)
      count_d = CW'(1);
    else if (run_i && (count_q != limit))
      count_d = count_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

`default_nettype wire

// File: rtl/menu_cursor.sv
// ---------------------------------------------------------------------------
// menu_cursor : saturating menu index driven by joystick press/hold-repeat
// Rev 1.0     : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module menu_cursor
  import pong_pkg::*;
#(
  parameter int N_ITEMS      = 3,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input logic          clock,
  input logic          reset,
  menu_cursor_if.slave bus_io
);

  localparam logic [1:0] LAST_ITEM = 2'(N_ITEMS - 1);

  cursor_state_e state_q, state_d;
  dir_e          dir_q, dir_d;
  dir_e          dir_in;
  logic [1:0]    value_q, value_d;
  logic          moved_q, moved_d;
  logic          step, load, run, expire;

  assign dir_in = decode_dir(bus_io.up, bus_io.down);
  assign run    = (state_q == CUR_DELAY) || (state_q == CUR_REPEAT);

  hold_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_hold_timer (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (!bus_io.enable),
    .load_i      (load),
    .run_i       (run),
    .limit_sel_i (state_q == CUR_REPEAT),
    .expire_o    (expire)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    value_d = value_q;
    moved_d = 1'b0;
    step    = 1'b0;
    load    = 1'b0;

    if (!bus_io.enable) begin
      state_d = CUR_LOCKED;
      dir_d   = DIR_NONE;
      value_d = MENU_CONTINUE;
    end else begin
      case (state_q)
        CUR_LOCKED: if (dir_in == DIR_NONE) state_d = CUR_IDLE;
        CUR_IDLE: begin
          if (dir_in != DIR_NONE) begin
            step    = 1'b1;
            load    = 1'b1;
            state_d = CUR_DELAY;
            dir_d   = dir_in;
          end
        end
        CUR_DELAY, CUR_REPEAT: begin
          if (dir_in == DIR_NONE) begin
            state_d = CUR_IDLE;
            dir_d   = DIR_NONE;
          end else if (dir_in != dir_q) begin
            step    = 1'b1;
            load    = 1'b1;
            state_d = CUR_DELAY;
            dir_d   = dir_in;
          end else if (expire) begin
            step    = 1'b1;
            load    = 1'b1;
            state_d = CUR_REPEAT;
          end
        end
        default: state_d = CUR_LOCKED;
      endcase
    end

    // Every step uses the direction sampled this cycle; saturated steps do not pulse moved.
    if (step) begin
      if (dir_in == DIR_UP && value_q != 2'd0) begin
        value_d = value_q - 2'd1;
        moved_d = 1'b1;
      end else if (dir_in == DIR_DN && value_q != LAST_ITEM) begin
        value_d = value_q + 2'd1;
        moved_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= CUR_LOCKED;
      dir_q   <= DIR_NONE;
      value_q <= MENU_CONTINUE;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      value_q <= value_d;
      moved_q <= moved_d;
    end
  end

  assign bus_io.value = value_q;
  assign bus_io.moved = moved_q;

endmodule

`default_nettype wire

// File: doc/menu_cursor.md
# menu_cursor

Cursor controller for the Pong start and pause menus. It converts joystick up/down levels into a saturating item index `value`, with press-edge stepping and hold-to-repeat. Its output drives the `value[1:0]` input of the main game FSM: 0 = Continue, 1 = Restart, 2 = Exit. It runs on the system clock, with `enable` driven high while a menu is shown.

## Interface

- `N_ITEMS`, default 3: number of menu items; legal range 2..4.
- `REPEAT_DELAY`, default 8: clock cycles a direction must be held before the first auto-repeat step.
- `REPEAT_RATE`, default 4: clock cycles between auto-repeat steps after the first.

- `clock`, in, 1: system clock, rising edge.
- `reset`, in, 1: synchronous, active-low.
- `enable`, in, 1: menu visible (start or pause menu active).
- `up`, in, 1: joystick up, already synchronized, active high.
- `down`, in, 1: joystick down, already synchronized, active high.
- `value`, out, 2: current item index, 0..N_ITEMS-1.
- `moved`, out, 1: one-cycle pulse, high the cycle after `value` changed.

## Operation

- Direction decode: `up&~down` = UP (index −1), `down&~up` = DN (index +1). Both high or both low = NONE.
- States:
  - LOCKED: no stepping. Exits to IDLE on the first cycle that samples NONE.
  - IDLE: waiting for a press.
  - DELAY: direction held, first-repeat wait.
  - REPEAT: auto-repeat.
- IDLE with UP or DN sampled: step once, load the hold counter, go to DELAY and latch the direction.
- DELAY: the counter reaching REPEAT_DELAY triggers a step, reloads the counter and moves to REPEAT.
- REPEAT: the counter reaching REPEAT_RATE triggers a step and reloads the counter.
- DELAY/REPEAT, NONE sampled: go to IDLE, no step.
- DELAY/REPEAT, opposite direction sampled: treat it as a fresh press. Step immediately in the new direction, reload the counter, go to DELAY.
- Stepping saturates with no wrap:
  - UP at 0 leaves `value` = 0.
  - DN at N_ITEMS-1 leaves `value` unchanged.
  - A saturated step does not pulse `moved`, but still restarts the hold timing.
- `enable` low:
  - next cycle `value` = 0, `moved` = 0, state = LOCKED;
  - inputs ignored;
  - every menu therefore opens on item 0;
  - a direction still held at menu entry is ignored until released.
- `enable` rising: the block starts from LOCKED. The first NONE cycle moves it to IDLE.
- Hold counter width: `$clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)`. The counter never wraps; it is reloaded on every step.

## Timing

- Reset values (at the edge sampling `reset`=0):
  - `value` = 0, `moved` = 0;
  - state = LOCKED;
  - hold counter = 0;
  - latched direction = NONE.
- Reset mid-hold: the block returns to LOCKED. The held direction is ignored until released.
- Press latency: direction first sampled at edge t gives an updated `value` after edge t, with `moved` high from edge t until edge t+1.
- Held direction: further steps at edges t+REPEAT_DELAY, then t+REPEAT_DELAY+k·REPEAT_RATE for k ≥ 1.
- Simultaneous events:
  - `enable` low overrides any press in the same cycle;
  - `reset` overrides everything.
- `value` is registered and glitch-free, so the main FSM can sample it on the cycle its `enter` is seen.

## Structure

- Shared package `pong_pkg` holds:
  - menu index constants MENU_CONTINUE=2'd0, MENU_RESTART=2'd1, MENU_EXIT=2'd2, shared with the main FSM's `value` decode;
  - the cursor state encoding (LOCKED, IDLE, DELAY, REPEAT);
  - the direction encoding (NONE, UP, DN).
- One sub-module is natural: `hold_timer`. It is the reloadable counter with `load`, `limit` select (DELAY/RATE) and an `expire` output.
- Decode, the state machine and the saturating index register stay in `menu_cursor`.

## Test plan

All scenarios use default parameters.

- Reset, then `enable`=1, `up`=`down`=0 for 3 cycles, then `down` high 1 cycle → `value` 0→1 the cycle after the press. `moved` is high exactly 1 cycle.
- `down` held 20 cycles from `value`=0, press at edge t → steps at t and t+8 (`value`=2). The step at t+12 saturates, `value` stays 2 and `moved` stays 0.
- `value`=2, `up` held 13 cycles → steps at t (1), t+8 (0) and t+12 (saturated: `value` 0, no `moved`).
- `down` held when `enable` rises → `value` stays 0 until `down` is released for ≥1 cycle. A following `down` press then gives `value`=1.
- `value`=1 with `up` and `down` both high → no change. `enable` dropped → `value`=0 on the next cycle.
- `down` held 5 cycles, then `reset` low for 1 cycle with `down` still held → `value`=0 and no further steps until `down` is released and pressed again.
